// File: rtl/svm_pkg.sv
// svm_pkg: shared fixed-point defaults, feeder state type and a bin slicing
// helper for the SVM parallel-element feeder and its score register.
package svm_pkg;

    localparam int FEA_I_DEF   = 4;
    localparam int FEA_F_DEF   = 28;
    localparam int FEA_N_DEF   = FEA_I_DEF + FEA_F_DEF;
    localparam int NUM_BLK_DEF = 105;
    localparam int BINS        = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DONE
    } feeder_state_t;

    // Bin k of a packed 9-bin cell bus, bin 0 in the LSBs.
    function automatic logic [FEA_N_DEF-1:0] bin_of(
        input logic [BINS*FEA_N_DEF-1:0] bus,
        input int unsigned               k
    );
        return bus[k*FEA_N_DEF +: FEA_N_DEF];
    endfunction

endpackage

// File: rtl/svm_score_reg.sv
// svm_score_reg: captures the final window sum, compares it against the
// detection threshold (signed, strict greater-than) and emits a one-cycle
// result strobe tagged with the window index.
module svm_score_reg #(
    parameter int FEA_N = svm_pkg::FEA_N_DEF,
    parameter int WIN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture,
    input  logic signed [FEA_N-1:0] sum,
    input  logic signed [FEA_N-1:0] thresh,
    input  logic        [WIN_W-1:0] cur_win,
    output logic signed [FEA_N-1:0] score,
    output logic                    detect,
    output logic                    valid,
    output logic        [WIN_W-1:0] win_idx
);

    // Result registers: score/detect/index hold until the next capture, valid pulses once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score   <= '0;
            detect  <= 1'b0;
            valid   <= 1'b0;
            win_idx <= '0;
        end else begin
            valid <= capture;
            if (capture) begin
                score   <= sum;
                detect  <= (sum > thresh);
                win_idx <= cur_win;
            end
        end
    end

endmodule

// File: rtl/svm_pe_feeder.sv
// svm_pe_feeder: feeds one HOG block (4 cells x 9 bins) at a time to an
// external SVM PE, fetching coefficients from a 1-cycle synchronous memory
// and looping the PE partial sum back. After NUM_BLK blocks the window score
// and detect flag are registered in svm_score_reg.
// Optional build macro SVM_FEEDER_BIAS_EN adds i_bias as the block-0 seed sum.
module svm_pe_feeder
    import svm_pkg::*;
#(
    parameter  int FEA_I   = FEA_I_DEF,
    parameter  int FEA_F   = FEA_F_DEF,
    parameter  int NUM_BLK = NUM_BLK_DEF,
    parameter  int BLK_W   = 7,
    parameter  int WIN_W   = 16,
    localparam int FEA_N   = FEA_I + FEA_F,
    localparam int CELL_W  = BINS * FEA_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CELL_W-1:0]       i_fea_a,
    input  logic [CELL_W-1:0]       i_fea_b,
    input  logic [CELL_W-1:0]       i_fea_c,
    input  logic [CELL_W-1:0]       i_fea_d,
    input  logic                    i_fea_valid,
    output logic                    o_fea_ready,
    input  logic signed [FEA_N-1:0] i_thresh,
`ifdef SVM_FEEDER_BIAS_EN
    input  logic signed [FEA_N-1:0] i_bias,
`endif
    output logic [BLK_W-1:0]        o_coef_addr,
    input  logic [4*CELL_W-1:0]     i_coef_rdata,
    output logic [CELL_W-1:0]       o_pe_fea_a,
    output logic [CELL_W-1:0]       o_pe_fea_b,
    output logic [CELL_W-1:0]       o_pe_fea_c,
    output logic [CELL_W-1:0]       o_pe_fea_d,
    output logic [CELL_W-1:0]       o_pe_coef_a,
    output logic [CELL_W-1:0]       o_pe_coef_b,
    output logic [CELL_W-1:0]       o_pe_coef_c,
    output logic [CELL_W-1:0]       o_pe_coef_d,
    output logic signed [FEA_N-1:0] o_pe_i_data,
    output logic                    o_pe_valid,
    input  logic signed [FEA_N-1:0] i_pe_o_data,
    output logic signed [FEA_N-1:0] o_score,
    output logic                    o_detect,
    output logic                    o_valid,
    output logic [WIN_W-1:0]        o_win_idx
);

    feeder_state_t           state;
    logic [BLK_W-1:0]        blk_idx;
    logic [WIN_W-1:0]        win_idx;
    logic [CELL_W-1:0]       fea_a_p0;
    logic [CELL_W-1:0]       fea_b_p0;
    logic [CELL_W-1:0]       fea_c_p0;
    logic [CELL_W-1:0]       fea_d_p0;
    logic signed [FEA_N-1:0] seed_sum;
    logic                    last_blk;

    assign last_blk = (blk_idx == BLK_W'(NUM_BLK - 1));

    // Block sequencing, coefficient addressing and feature hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            blk_idx     <= '0;
            win_idx     <= '0;
            o_coef_addr <= '0;
            fea_a_p0    <= '0;
            fea_b_p0    <= '0;
            fea_c_p0    <= '0;
            fea_d_p0    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_fea_valid) begin
                        fea_a_p0    <= i_fea_a;
                        fea_b_p0    <= i_fea_b;
                        fea_c_p0    <= i_fea_c;
                        fea_d_p0    <= i_fea_d;
                        o_coef_addr <= blk_idx;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (last_blk) begin
                        state <= ST_DONE;
                    end else begin
                        blk_idx <= blk_idx + BLK_W'(1);
                        state   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    win_idx <= win_idx + WIN_W'(1);
                    blk_idx <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SVM_FEEDER_BIAS_EN
    assign seed_sum = i_bias;
`else
    assign seed_sum = '0;
`endif

    // Stage boundary: held features and memory word go straight to the PE in ISSUE.
    assign o_fea_ready = (state == ST_IDLE);
    assign o_pe_valid  = (state == ST_ISSUE);
    assign o_pe_i_data = (blk_idx == '0) ? seed_sum : i_pe_o_data;
    assign o_pe_fea_a  = fea_a_p0;
    assign o_pe_fea_b  = fea_b_p0;
    assign o_pe_fea_c  = fea_c_p0;
    assign o_pe_fea_d  = fea_d_p0;
    assign o_pe_coef_a = i_coef_rdata[0*CELL_W +: CELL_W];
    assign o_pe_coef_b = i_coef_rdata[1*CELL_W +: CELL_W];
    assign o_pe_coef_c = i_coef_rdata[2*CELL_W +: CELL_W];
    assign o_pe_coef_d = i_coef_rdata[3*CELL_W +: CELL_W];

    svm_score_reg #(
        .FEA_N (FEA_N),
        .WIN_W (WIN_W)
    ) u_score_reg (
        .clk     (clk),
        .rst     (rst),
        .capture (state == ST_DONE),
        .sum     (i_pe_o_data),
        .thresh  (i_thresh),
        .cur_win (win_idx),
        .score   (o_score),
        .detect  (o_detect),
        .valid   (o_valid),
        .win_idx (o_win_idx)
    );

endmodule

// File: tb/tb_svm_pe_feeder.sv
// tb_svm_pe_feeder: directed and randomized bench for svm_pe_feeder with a
// 2-block window, a 1-cycle coefficient memory and a behavioural PE.
module tb_svm_pe_feeder;

    localparam int NB = 2;
    localparam int FN = 32;
    localparam int CW = 9 * FN;
    localparam logic [FN-1:0] Q_P125 = 32'h0200_0000;
    localparam logic [FN-1:0] Q_M125 = 32'hFE00_0000;

    logic            clk;
    logic            rst;
    logic [CW-1:0]   i_fea_a, i_fea_b, i_fea_c, i_fea_d;
    logic            i_fea_valid;
    logic            o_fea_ready;
    logic [FN-1:0]   i_thresh;
    logic [FN-1:0]   i_bias;
    logic [6:0]      o_coef_addr;
    logic [4*CW-1:0] coef_rdata;
    logic [CW-1:0]   pe_fea_a, pe_fea_b, pe_fea_c, pe_fea_d;
    logic [CW-1:0]   pe_coef_a, pe_coef_b, pe_coef_c, pe_coef_d;
    logic [FN-1:0]   pe_i_data;
    logic            pe_valid;
    logic [FN-1:0]   pe_acc;
    logic [FN-1:0]   o_score;
    logic            o_detect;
    logic            o_valid;
    logic [15:0]     o_win_idx;

    logic [CW-1:0]   fea_tab [NB][4];
    logic [4*CW-1:0] mem [NB];

    int n_checks = 0;
    int n_fail   = 0;
    int win_expect = 0;

    svm_pe_feeder #(.NUM_BLK(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fea_a      (i_fea_a),
        .i_fea_b      (i_fea_b),
        .i_fea_c      (i_fea_c),
        .i_fea_d      (i_fea_d),
        .i_fea_valid  (i_fea_valid),
        .o_fea_ready  (o_fea_ready),
        .i_thresh     (i_thresh),
`ifdef SVM_FEEDER_BIAS_EN
        .i_bias       (i_bias),
`endif
        .o_coef_addr  (o_coef_addr),
        .i_coef_rdata (coef_rdata),
        .o_pe_fea_a   (pe_fea_a),
        .o_pe_fea_b   (pe_fea_b),
        .o_pe_fea_c   (pe_fea_c),
        .o_pe_fea_d   (pe_fea_d),
        .o_pe_coef_a  (pe_coef_a),
        .o_pe_coef_b  (pe_coef_b),
        .o_pe_coef_c  (pe_coef_c),
        .o_pe_coef_d  (pe_coef_d),
        .o_pe_i_data  (pe_i_data),
        .o_pe_valid   (pe_valid),
        .i_pe_o_data  (pe_acc),
        .o_score      (o_score),
        .o_detect     (o_detect),
        .o_valid      (o_valid),
        .o_win_idx    (o_win_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sum over bins of fixed-point products (Q4.28 * Q4.28 >> 28).
    function automatic longint cell_dot(input logic [CW-1:0] f, input logic [CW-1:0] c);
        longint acc = 0;
        for (int k = 0; k < 9; k++)
            acc += (longint'($signed(svm_pkg::bin_of(f, k))) *
                    longint'($signed(svm_pkg::bin_of(c, k)))) >>> 28;
        return acc;
    endfunction

    // Synchronous coefficient memory, one cycle of read latency.
    always @(posedge clk) coef_rdata <= mem[o_coef_addr[0]];

    // External PE: registered partial sum, updated on each strobe.
    always @(posedge clk or negedge rst) begin
        if (!rst) pe_acc <= '0;
        else if (pe_valid)
            pe_acc <= FN'(longint'($signed(pe_i_data)) + cell_dot(pe_fea_a, pe_coef_a) +
                          cell_dot(pe_fea_b, pe_coef_b) + cell_dot(pe_fea_c, pe_coef_c) +
                          cell_dot(pe_fea_d, pe_coef_d));
    end

    // Whole-window score straight from the stimulus tables, wrapped to FN bits.
    function automatic logic [FN-1:0] ref_score();
        longint acc = 0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < 4; c++)
                acc += cell_dot(fea_tab[b][c], mem[b][c*CW +: CW]);
`ifdef SVM_FEEDER_BIAS_EN
        acc += longint'($signed(i_bias));
`endif
        return acc[FN-1:0];
    endfunction

    function automatic logic [CW-1:0] fill(input logic [FN-1:0] v);
        logic [CW-1:0] r;
        for (int k = 0; k < 9; k++) r[k*FN +: FN] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd_cell();
        logic [CW-1:0] r;
        for (int k = 0; k < 9; k++) r[k*FN +: FN] = FN'($urandom());
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_tables(input logic [FN-1:0] fv, input logic [FN-1:0] cv);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 4; c++) fea_tab[b][c] = fill(fv);
            mem[b] = {4{fill(cv)}};
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_rdy"},   o_fea_ready, 1);
        check({tag, "_pev"},   pe_valid, 0);
        check({tag, "_vld"},   o_valid, 0);
        check({tag, "_addr"},  o_coef_addr, 0);
        check({tag, "_score"}, o_score, 0);
        check({tag, "_det"},   o_detect, 0);
        check({tag, "_win"},   o_win_idx, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        win_expect = 0;
    endtask

    task automatic feed_block(input int b);
        int n = 0;
        while (!o_fea_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", (n < 20), 1);
        i_fea_a = fea_tab[b][0];
        i_fea_b = fea_tab[b][1];
        i_fea_c = fea_tab[b][2];
        i_fea_d = fea_tab[b][3];
        i_fea_valid = 1'b1;
        @(posedge clk);
        #1;
        i_fea_valid = 1'b0;
    endtask

    task automatic run_window(input string tag, input logic [FN-1:0] exp_s);
        int n = 0;
        logic exp_d;
        exp_d = $signed(exp_s) > $signed(i_thresh);
        for (int b = 0; b < NB; b++) begin
            feed_block(b);
            check($sformatf("%s_addr%0d", tag, b), o_coef_addr, b);
            check($sformatf("%s_novld%0d", tag, b), o_valid, 0);
        end
        while (!o_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_vld"},   o_valid, 1);
        check({tag, "_score"}, o_score, exp_s);
        check({tag, "_det"},   o_detect, exp_d);
        check({tag, "_win"},   o_win_idx, win_expect);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, o_valid, 0);
        check({tag, "_hold"},  o_score, exp_s);
        win_expect++;
    endtask

    initial begin
        int e_rdy[$], e_pev[$], e_addr[$], e_vld[$];
        int vseen;
        rst = 1'b0;
        i_fea_valid = 1'b0;
        i_fea_a = '0; i_fea_b = '0; i_fea_c = '0; i_fea_d = '0;
        i_thresh = 32'h1000_0000;
        i_bias = '0;
        set_tables(Q_P125, Q_P125);
        @(posedge clk);
        #1;
        apply_reset("rst0");

        // Basic score, negative path, threshold equality
        run_window("basic", 32'h1200_0000);
        set_tables(Q_P125, Q_M125);
        run_window("neg", 32'hEE00_0000);
        set_tables(Q_P125, Q_P125);
        i_thresh = 32'h1200_0000;
        run_window("eq", 32'h1200_0000);
        i_thresh = 32'h11FF_FFFF;
        run_window("justbelow", 32'h1200_0000);
`ifdef SVM_FEEDER_BIAS_EN
        i_thresh = 32'h1000_0000;
        i_bias = 32'h0400_0000;
        run_window("bias", 32'h1600_0000);
        i_bias = '0;
`endif

        // Randomized windows against the whole-window reference
        for (int r = 0; r < 6; r++) begin
            for (int b = 0; b < NB; b++) begin
                for (int c = 0; c < 4; c++) fea_tab[b][c] = rnd_cell();
                mem[b] = {rnd_cell(), rnd_cell(), rnd_cell(), rnd_cell()};
            end
            i_thresh = (r == 3) ? ref_score() : FN'($urandom());
`ifdef SVM_FEEDER_BIAS_EN
            i_bias = FN'($urandom());
`endif
            run_window($sformatf("rand%0d", r), ref_score());
        end
        i_bias = '0;

        // Back-to-back handshake over two windows with valid held high
        apply_reset("rst1");
        set_tables(Q_P125, Q_P125);
        i_thresh = 32'h1000_0000;
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < NB; b++) begin
                e_rdy.push_back(1); e_pev.push_back(0); e_addr.push_back(-1);
                e_vld.push_back((b == 0 && w > 0) ? 1 : 0);
                e_rdy.push_back(0); e_pev.push_back(0); e_addr.push_back(b); e_vld.push_back(0);
                e_rdy.push_back(0); e_pev.push_back(1); e_addr.push_back(b); e_vld.push_back(0);
            end
            e_rdy.push_back(0); e_pev.push_back(0); e_addr.push_back(-1); e_vld.push_back(0);
        end
        e_rdy.push_back(1); e_pev.push_back(0); e_addr.push_back(-1); e_vld.push_back(1);
        i_fea_a = fea_tab[0][0]; i_fea_b = fea_tab[0][1];
        i_fea_c = fea_tab[0][2]; i_fea_d = fea_tab[0][3];
        i_fea_valid = 1'b1;
        vseen = 0;
        for (int k = 0; k < e_rdy.size(); k++) begin
            check($sformatf("hs_rdy%0d", k), o_fea_ready, e_rdy[k]);
            check($sformatf("hs_pev%0d", k), pe_valid, e_pev[k]);
            check($sformatf("hs_vld%0d", k), o_valid, e_vld[k]);
            if (e_addr[k] >= 0) check($sformatf("hs_addr%0d", k), o_coef_addr, e_addr[k]);
            if (o_valid) begin
                check($sformatf("hs_win%0d", vseen), o_win_idx, vseen);
                check($sformatf("hs_score%0d", vseen), o_score, 32'h1200_0000);
                vseen++;
            end
            if (k == e_rdy.size() - 1) i_fea_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("hs_pulses", vseen, 2);
        win_expect = 2;

        // Reset in the middle of a window
        begin
            int n = 0;
            feed_block(0);
            while (!pe_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("mid_issue_seen", pe_valid, 1);
            @(posedge clk);
            #1;
        end
        apply_reset("mid");
        run_window("after_rst", 32'h1200_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/svm_pe_feeder.md
Name: svm_pe_feeder

Overview:
- Drives the SVM parallel-element datapath one HOG block at a time.
- Accepts 4-cell HOG blocks (36 signed features), fetches the matching 36 SVM coefficients from a synchronous coefficient memory, and issues feature, coefficient and partial-sum words to the PE.
- Loops the PE's registered partial sum back as the next block's input.
- After NUM_BLK blocks it registers the window score and a detect flag.

Parameters:
- FEA_I, 4, integer bits of a signed fixed-point feature/coefficient/score.
- FEA_F, 28, fractional bits; FEA_N = FEA_I + FEA_F.
- NUM_BLK, 105, HOG blocks per detection window (7x15 for a 64x128 window).
- BLK_W, 7, block index width; must satisfy 2^BLK_W >= NUM_BLK.
- WIN_W, 16, window counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- i_fea_a/b/c/d  in  9*FEA_N each  cell features, bin 0 in LSBs
- i_fea_valid  in  1  block features valid
- o_fea_ready  out  1  feeder can accept a block
- i_thresh  in  FEA_N  signed detection threshold
- o_coef_addr  out  BLK_W  coefficient memory address (block index)
- i_coef_rdata  in  36*FEA_N  coefficients {d,c,b,a}, valid one cycle after address
- o_pe_fea_a/b/c/d  out  9*FEA_N each  features to PE
- o_pe_coef_a/b/c/d  out  9*FEA_N each  coefficients to PE
- o_pe_i_data  out  FEA_N  partial sum into PE
- o_pe_valid  out  1  PE update strobe
- i_pe_o_data  in  FEA_N  PE registered partial sum (1-cycle latency)
- o_score  out  FEA_N  final window score
- o_detect  out  1  score > threshold (signed)
- o_valid  out  1  score/detect valid pulse
- o_win_idx  out  WIN_W  index of window reported with o_valid

Behaviour:
- Reset (rst=0, async): state IDLE, blk_idx=0, win_idx=0, feature regs 0, o_coef_addr=0, o_score=0, o_detect=0, o_valid=0, o_win_idx=0. o_pe_valid=0 immediately.
- States: IDLE, FETCH, ISSUE, DONE.
- IDLE: o_fea_ready=1. On i_fea_valid: register i_fea_a..d, o_coef_addr<=blk_idx, go to FETCH. Ready is 0 in every other state; features are never dropped.
- FETCH: memory samples the address. Go to ISSUE.
- ISSUE:
  - o_pe_valid=1. o_pe_coef_* = i_coef_rdata slices (combinational pass-through). o_pe_fea_* = held regs.
  - o_pe_i_data = 0 when blk_idx==0, else i_pe_o_data.
  - If blk_idx==NUM_BLK-1, go to DONE; otherwise blk_idx++ and go to IDLE.
- DONE: i_pe_o_data now holds the final sum.
  - At the edge: o_score<=i_pe_o_data, o_detect<=($signed(i_pe_o_data) > $signed(i_thresh)), o_valid<=1, o_win_idx<=win_idx.
  - Then win_idx++ (wraps modulo 2^WIN_W), blk_idx<=0, go to IDLE.
- o_valid is a one-cycle pulse, high in the first IDLE cycle after DONE. There is no backpressure on results.
- Throughput: 3 cycles per block when i_fea_valid is held high, plus 1 cycle per window (DONE).
- o_pe_fea_*, o_pe_i_data and o_pe_coef_* are don't-care when o_pe_valid=0 but must be held stable, not X.
- Arithmetic: no saturation; the score wraps in FEA_N two's complement, consistent with the PE.
- o_score/o_detect hold until the next DONE.
- Reset mid-window discards the partial sum; the next accepted block is blk_idx 0.

Optional Feature:
- Macro: SVM_FEEDER_BIAS_EN.
- Defined: adds input port i_bias (FEA_N, signed). Block 0 drives o_pe_i_data = i_bias instead of 0. i_bias is sampled in ISSUE.
- Undefined: the port is absent and the initial partial sum is 0.

Decomposition:
- Shared package svm_pkg:
  - FEA_I/FEA_F defaults and the FEA_N localparam.
  - NUM_BLK default.
  - Feeder state enum (IDLE, FETCH, ISSUE, DONE).
  - Helper for slicing bin k of a packed 9*FEA_N bus.
- Sub-module: svm_score_reg, holding o_score/o_detect/o_valid/o_win_idx registration and the signed compare.
- The FSM and feature hold stay in the top level. The PE remains external.

Test Plan:
Bench uses NUM_BLK=2, default widths, a 1-cycle-latency memory model and a real PE. 0x0200_0000 = 0.125.
- Basic score: all features 0.125, all coefficients 0.125, thresh 0x1000_0000 -> after 2 blocks o_score=0x1200_0000 (1.125), o_detect=1, o_valid one cycle, o_win_idx=0.
- Negative path: coefficients -0.125 (0xFE00_0000), same features -> o_score=0xEE00_0000 (-1.125), o_detect=0.
- Bias (SVM_FEEDER_BIAS_EN defined): i_bias=0x0400_0000 on the basic-score stimulus -> o_score=0x1600_0000.
- Handshake: i_fea_valid held high for 4 blocks -> o_fea_ready high only in IDLE, blocks accepted 3 cycles apart, two o_valid pulses with o_win_idx 0 then 1, o_coef_addr sequence 0,1,0,1.
- Reset mid-window: deassert rst after block 0 is issued, release, feed 2 blocks -> no stale o_valid, o_coef_addr starts at 0, score equals the basic-score case.
- Threshold equality: thresh equal to the score (0x1200_0000) -> o_detect=0 (strict greater-than).
